// File: rtl/sensor_stream_model.sv
// ---------------------------------------------------------------------------
// sensor_stream_model
//   Synthesizable sensor stimulus source. Plays back samples from an internal
//   memory onto the CPU-side sensor interface. One sample is emitted every
//   INTERVAL enabled cycles. Channels are visited round-robin inside each
//   sample index. Playback either wraps or stops with o_done. Delivery is a
//   one-cycle pulse, or (HOLD=1) a sample held until acknowledged, with
//   overrun accounting.
//
// Ports
//   i_clk          clock, all logic on the rising edge
//   i_rst          synchronous active-high reset (memory is not cleared)
//   i_sensor_en    consumer enable; gates interval counting and masks ready
//   i_sensor_ack   consumer took the sample (HOLD=1 only)
//   i_load_en      sample memory write strobe (usable at any time)
//   i_load_addr    write address, layout idx*NUM_CH+ch
//   i_load_data    write data
//   o_sensor_ready sample valid (pending & enable)
//   o_sensor_out   sample data
//   o_sensor_ch    channel of the presented sample
//   o_done         one-shot playback finished (sticky)
//   o_overrun_cnt  samples replaced while still pending, saturating
// ---------------------------------------------------------------------------
module sensor_stream_model #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 512,
  parameter int NUM_CH   = 1,
  parameter int INTERVAL = 1024,
  parameter int WRAP     = 1,
  parameter int HOLD     = 0,
  localparam int MEM_N   = NUM_CH * DEPTH,
  localparam int AW      = (MEM_N  > 1) ? $clog2(MEM_N)  : 1,
  localparam int CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sensor_en,
  input  logic              i_sensor_ack,
  input  logic              i_load_en,
  input  logic [AW-1:0]     i_load_addr,
  input  logic [DATA_W-1:0] i_load_data,
  output logic              o_sensor_ready,
  output logic [DATA_W-1:0] o_sensor_out,
  output logic [CW-1:0]     o_sensor_ch,
  output logic              o_done,
  output logic [15:0]       o_overrun_cnt
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(INTERVAL);

  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(INTERVAL - 1);
  localparam logic [IDXW-1:0] IDX_MAX = IDXW'(DEPTH - 1);
  localparam logic [CW-1:0]   CH_MAX  = CW'(NUM_CH - 1);
  localparam logic [AW-1:0]   CH_MUL  = AW'(NUM_CH);

  // Sample memory (not reset; contents survive i_rst)
  logic [DATA_W-1:0] r_mem [MEM_N];

  logic [CNTW-1:0]   r_cnt;
  logic [IDXW-1:0]   r_idx;
  logic [CW-1:0]     r_ch;
  logic              r_pending;
  logic [DATA_W-1:0] r_out;
  logic [CW-1:0]     r_out_ch;
  logic              r_done;
  logic [15:0]       r_ovr;

  logic              w_tick;
  logic              w_emit;
  logic              w_last_ch;
  logic              w_last;
  logic              w_ready;
  logic              w_ack;
  logic [AW-1:0]     w_rd_addr;

  // Counting only happens while enabled and playback is not finished.
  assign w_tick    = i_sensor_en & ~r_done;
  assign w_emit    = w_tick & (r_cnt == CNT_MAX);
  assign w_last_ch = (r_ch == CH_MAX);
  assign w_last    = w_last_ch & (r_idx == IDX_MAX);
  assign w_ready   = r_pending & i_sensor_en;
  // Ack is only honoured while the sample is actually visible.
  assign w_ack     = (HOLD != 0) & i_sensor_ack & w_ready;
  assign w_rd_addr = AW'(r_idx) * CH_MUL + AW'(r_ch);

  // Load port. Out-of-range addresses (non power-of-two sizes) are dropped.
  always_ff @(posedge i_clk) begin
    if (i_load_en && (32'(i_load_addr) < 32'(MEM_N)))
      r_mem[i_load_addr] <= i_load_data;
  end

  // Interval counter; freezes while disabled or after done.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_cnt <= '0;
    else if (w_tick)
      r_cnt <= w_emit ? '0 : r_cnt + 1'b1;
  end

  // Playback position and registered sample outputs. A same-edge load to the
  // read address is not visible here: the memory update and this read are
  // both non-blocking, so the emission takes the old word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx    <= '0;
      r_ch     <= '0;
      r_out    <= '0;
      r_out_ch <= '0;
      r_done   <= 1'b0;
    end else if (w_emit) begin
      r_out    <= r_mem[w_rd_addr];
      r_out_ch <= r_ch;
      if (w_last_ch) begin
        r_ch <= '0;
        if (w_last) begin
          r_idx <= '0;
          if (WRAP == 0)
            r_done <= 1'b1;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end else begin
        r_ch <= r_ch + 1'b1;
      end
    end
  end

  // Pending flag and overrun accounting.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending <= 1'b0;
      r_ovr     <= '0;
    end else if (HOLD == 0) begin
      // Pulse mode: live for one enabled cycle. A disabled edge holds the
      // flag so the pulse is masked rather than lost mid-cycle.
      if (w_emit)
        r_pending <= 1'b1;
      else if (i_sensor_en)
        r_pending <= 1'b0;
    end else begin
      if (w_emit) begin
        r_pending <= 1'b1;
        // Replacing an unacknowledged sample counts as an overrun; an ack on
        // the same edge means the old one was consumed in time.
        if (r_pending && !w_ack && (r_ovr != 16'hFFFF))
          r_ovr <= r_ovr + 16'd1;
      end else if (w_ack) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign o_sensor_ready = w_ready;
  assign o_sensor_out   = r_out;
  assign o_sensor_ch    = r_out_ch;
  assign o_done         = r_done;
  assign o_overrun_cnt  = r_ovr;

endmodule

// File: tb/tb_sensor_stream_model.sv
// ---------------------------------------------------------------------------
// tb_sensor_stream_model
//   Directed bench. Five instances with different parameter sets share one
//   clock: default pulse (d_), enable gating (g_), multi-channel one-shot
//   (m_), hold handshake (h_) and wrap/reset (w_). Tests run one after the
//   other; idle instances sit with enable low.
// ---------------------------------------------------------------------------
module tb_sensor_stream_model;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // ---- default instance ----
  logic        d_rst, d_en, d_ack, d_ld;
  logic [8:0]  d_addr;
  logic [31:0] d_data, d_out;
  logic        d_rdy, d_done;
  logic [0:0]  d_ch;
  logic [15:0] d_ovr;

  sensor_stream_model u_d (
    .i_clk(clk), .i_rst(d_rst), .i_sensor_en(d_en), .i_sensor_ack(d_ack),
    .i_load_en(d_ld), .i_load_addr(d_addr), .i_load_data(d_data),
    .o_sensor_ready(d_rdy), .o_sensor_out(d_out), .o_sensor_ch(d_ch),
    .o_done(d_done), .o_overrun_cnt(d_ovr));

  // ---- gating instance ----
  logic        g_rst, g_en, g_ack, g_ld;
  logic [1:0]  g_addr;
  logic [31:0] g_data, g_out;
  logic        g_rdy, g_done;
  logic [0:0]  g_ch;
  logic [15:0] g_ovr;

  sensor_stream_model #(.DEPTH(4), .INTERVAL(4)) u_g (
    .i_clk(clk), .i_rst(g_rst), .i_sensor_en(g_en), .i_sensor_ack(g_ack),
    .i_load_en(g_ld), .i_load_addr(g_addr), .i_load_data(g_data),
    .o_sensor_ready(g_rdy), .o_sensor_out(g_out), .o_sensor_ch(g_ch),
    .o_done(g_done), .o_overrun_cnt(g_ovr));

  // ---- multi-channel one-shot instance ----
  logic        m_rst, m_en, m_ack, m_ld;
  logic [2:0]  m_addr;
  logic [31:0] m_data, m_out;
  logic        m_rdy, m_done;
  logic [0:0]  m_ch;
  logic [15:0] m_ovr;

  sensor_stream_model #(.DEPTH(3), .NUM_CH(2), .INTERVAL(2), .WRAP(0)) u_m (
    .i_clk(clk), .i_rst(m_rst), .i_sensor_en(m_en), .i_sensor_ack(m_ack),
    .i_load_en(m_ld), .i_load_addr(m_addr), .i_load_data(m_data),
    .o_sensor_ready(m_rdy), .o_sensor_out(m_out), .o_sensor_ch(m_ch),
    .o_done(m_done), .o_overrun_cnt(m_ovr));

  // ---- hold handshake instance ----
  logic        h_rst, h_en, h_ack, h_ld;
  logic [2:0]  h_addr;
  logic [31:0] h_data, h_out;
  logic        h_rdy, h_done;
  logic [0:0]  h_ch;
  logic [15:0] h_ovr;

  sensor_stream_model #(.DEPTH(8), .INTERVAL(4), .HOLD(1)) u_h (
    .i_clk(clk), .i_rst(h_rst), .i_sensor_en(h_en), .i_sensor_ack(h_ack),
    .i_load_en(h_ld), .i_load_addr(h_addr), .i_load_data(h_data),
    .o_sensor_ready(h_rdy), .o_sensor_out(h_out), .o_sensor_ch(h_ch),
    .o_done(h_done), .o_overrun_cnt(h_ovr));

  // ---- wrap/reset instance ----
  logic        w_rst, w_en, w_ack, w_ld;
  logic [1:0]  w_addr;
  logic [31:0] w_data, w_out;
  logic        w_rdy, w_done;
  logic [0:0]  w_ch;
  logic [15:0] w_ovr;

  sensor_stream_model #(.DEPTH(4), .INTERVAL(2), .WRAP(1)) u_w (
    .i_clk(clk), .i_rst(w_rst), .i_sensor_en(w_en), .i_sensor_ack(w_ack),
    .i_load_en(w_ld), .i_load_addr(w_addr), .i_load_data(w_data),
    .o_sensor_ready(w_rdy), .o_sensor_out(w_out), .o_sensor_ch(w_ch),
    .o_done(w_done), .o_overrun_cnt(w_ovr));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  int pulses;

  initial begin
    {d_rst, g_rst, m_rst, h_rst, w_rst} = 5'b11111;
    {d_en,  g_en,  m_en,  h_en,  w_en } = '0;
    {d_ack, g_ack, m_ack, h_ack, w_ack} = '0;
    {d_ld,  g_ld,  m_ld,  h_ld,  w_ld } = '0;
    d_addr = '0; g_addr = '0; m_addr = '0; h_addr = '0; w_addr = '0;
    d_data = '0; g_data = '0; m_data = '0; h_data = '0; w_data = '0;
    step; step;
    {d_rst, g_rst, m_rst, h_rst, w_rst} = '0;

    // Reset state
    chk("rst_ready", 32'(d_rdy),  32'd0);
    chk("rst_out",   d_out,       32'd0);
    chk("rst_ch",    32'(d_ch),   32'd0);
    chk("rst_done",  32'(d_done), 32'd0);
    chk("rst_ovr",   32'(d_ovr),  32'd0);

    // Load all memories while every instance is idle
    for (int k = 0; k < 8; k++) begin
      d_ld = (k < 4); d_addr = 9'(k); d_data = 32'h1000_0000 + 32'(k);
      g_ld = (k < 4); g_addr = 2'(k); g_data = 32'h0000_0055 + 32'(k);
      m_ld = (k < 6); m_addr = 3'(k); m_data = 32'h0000_00C0 + 32'(k);
      h_ld = 1'b1;    h_addr = 3'(k); h_data = 32'h0000_00A0 + 32'(k);
      w_ld = (k < 4); w_addr = 2'(k); w_data = 32'h0000_00D0 + 32'(k);
      step;
    end
    {d_ld, g_ld, m_ld, h_ld, w_ld} = '0;
    chk("idle_ready", 32'(d_rdy), 32'd0);

    // ---- basic pulse, INTERVAL=1024 ----
    d_en = 1'b1;
    pulses = 0;
    repeat (1023) begin
      step;
      if (d_rdy) pulses++;
    end
    chk("d_early", 32'(pulses), 32'd0);
    step;
    chk("d_rdy0", 32'(d_rdy), 32'd1);
    chk("d_out0", d_out, 32'h1000_0000);
    step;
    chk("d_pulse", 32'(d_rdy), 32'd0);
    chk("d_hold", d_out, 32'h1000_0000);
    repeat (1022) step;
    chk("d_gap", 32'(d_rdy), 32'd0);
    step;
    chk("d_rdy1", 32'(d_rdy), 32'd1);
    chk("d_out1", d_out, 32'h1000_0001);
    chk("d_ovr", 32'(d_ovr), 32'd0);
    d_en = 1'b0;

    // ---- enable gating, INTERVAL=4 ----
    g_en = 1'b1;
    step; chk("g_e1", 32'(g_rdy), 32'd0);
    step; chk("g_e2", 32'(g_rdy), 32'd0);
    g_en = 1'b0;
    pulses = 0;
    repeat (5) begin
      step;
      if (g_rdy) pulses++;
    end
    chk("g_off", 32'(pulses), 32'd0);
    g_en = 1'b1;
    step; chk("g_e3", 32'(g_rdy), 32'd0);
    step; chk("g_e4", 32'(g_rdy), 32'd1);
    chk("g_out", g_out, 32'h0000_0055);
    step; chk("g_end", 32'(g_rdy), 32'd0);
    g_en = 1'b0;

    // ---- multi-channel one-shot ----
    m_en = 1'b1;
    for (int e = 0; e < 6; e++) begin
      step; chk("m_gap", 32'(m_rdy), 32'd0);
      step;
      chk("m_rdy",  32'(m_rdy),  32'd1);
      chk("m_ch",   32'(m_ch),   32'(e % 2));
      chk("m_out",  m_out,       32'h0000_00C0 + 32'(e));
      chk("m_done", 32'(m_done), (e == 5) ? 32'd1 : 32'd0);
    end
    pulses = 0;
    repeat (20) begin
      step;
      if (m_rdy) pulses++;
    end
    chk("m_no7th", 32'(pulses), 32'd0);
    chk("m_sticky", 32'(m_done), 32'd1);
    chk("m_final", m_out, 32'h0000_00C5);
    m_en = 1'b0;

    // ---- hold handshake, INTERVAL=4 ----
    h_en = 1'b1;
    repeat (3) step;
    chk("h_pre", 32'(h_rdy), 32'd0);
    step;
    chk("h_e1", 32'(h_rdy), 32'd1);
    chk("h_d1", h_out, 32'h0000_00A0);
    step; step;
    chk("h_held", 32'(h_rdy), 32'd1);
    h_ack = 1'b1;
    step;
    h_ack = 1'b0;
    chk("h_acked", 32'(h_rdy), 32'd0);
    chk("h_ovr0", 32'(h_ovr), 32'd0);
    step;
    chk("h_e2", h_out, 32'h0000_00A1);
    repeat (8) step;
    chk("h_ovr2", 32'(h_ovr), 32'd2);
    chk("h_newest", h_out, 32'h0000_00A3);
    chk("h_rdy4", 32'(h_rdy), 32'd1);
    repeat (3) step;
    h_ack = 1'b1;
    step;
    h_ack = 1'b0;
    chk("h_same_ovr", 32'(h_ovr), 32'd2);
    chk("h_same_rdy", 32'(h_rdy), 32'd1);
    chk("h_same_out", h_out, 32'h0000_00A4);
    h_en = 1'b0;
    step;
    chk("h_mask", 32'(h_rdy), 32'd0);
    h_en = 1'b1;
    #1;
    chk("h_repres", 32'(h_rdy), 32'd1);
    chk("h_repdat", h_out, 32'h0000_00A4);
    h_en = 1'b0;

    // ---- wrap and reset, DEPTH=4, INTERVAL=2 ----
    w_en = 1'b1;
    for (int e = 0; e < 5; e++) begin
      step; chk("w_gap", 32'(w_rdy), 32'd0);
      step;
      chk("w_rdy", 32'(w_rdy), 32'd1);
      chk("w_out", w_out, 32'h0000_00D0 + 32'(e % 4));
    end
    step;
    w_rst = 1'b1;              // reset lands on the 6th emission edge
    step;
    w_rst = 1'b0;
    chk("w_rst_rdy", 32'(w_rdy), 32'd0);
    chk("w_rst_out", w_out,      32'd0);
    chk("w_rst_ch",  32'(w_ch),  32'd0);
    step;
    chk("w_re1", 32'(w_rdy), 32'd0);
    step;
    chk("w_re2", 32'(w_rdy), 32'd1);
    chk("w_mem0", w_out, 32'h0000_00D0);
    step; step;
    chk("w_mem1", w_out, 32'h0000_00D1);
    w_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
